rom_dl_sequencer: RTL

ROM_DL_SEQUENCER -- requirements
Module: rom_dl_sequencer

---
 rtl/rom_dl_sequencer_if.sv | 37 +++
 rtl/rom_dl_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_sequencer_if.sv
// HPS download bus and core ROM write port used by rom_dl_sequencer.
// master: the HPS/core environment side; slave: the sequencer.
interface rom_dl_sequencer_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        slot_en;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;

    modport master (
        output ioctl_download,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        output slot_en,
        input  ioctl_wait,
        input  dn_addr,
        input  dn_data,
        input  dn_wr
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        input  slot_en,
        output ioctl_wait,
        output dn_addr,
        output dn_data,
        output dn_wr
    );
endinterface

// File: rtl/rom_dl_sequencer.sv
// ROM download sequencer: buffers HPS byte strobes into core ROM write slots,
// checks the download for completeness, and holds the game core in reset
// until a download (or a soft reset) has settled.
//
// state | meaning
// IDLE  | after power-up, core held in reset, waiting for first download
// LOAD  | download window open, bytes buffered and issued
// DRAIN | window closed, waiting for the buffered byte to be issued
// HOLD  | core held in reset for HOLD_CYC cycles
// RUN   | core released
module rom_dl_sequencer #(
    parameter int unsigned ROM_SIZE = 40960,
    parameter int unsigned HOLD_CYC = 16
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    rom_dl_sequencer_if.slave   bus,
    input  logic                soft_reset,
    output logic                core_reset,
    output logic                dl_done,
    output logic                dl_error
);

    localparam logic [24:0] ROM_LIMIT = 25'(ROM_SIZE);
    localparam logic [16:0] ROM_COUNT = 17'(ROM_SIZE);
    localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYC);
    localparam logic [16:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_HOLD  = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        armed;
    logic        dl_q;

    logic        buf_valid;
    logic [15:0] buf_addr;
    logic [7:0]  buf_data;
    logic [15:0] out_addr;
    logic [7:0]  out_data;

    logic [16:0] byte_cnt;
    logic        overflow;
    logic [7:0]  hold_cnt;

    logic        dl_rise;
    logic        dl_fall;
    logic        in_window;
    logic        addr_ok;
    logic        issue;
    logic        accept;
    logic        reject;
    logic        hold_done;
    logic        enter_load;
    logic        enter_hold;
    logic        drain_exit;

    // Edge detect is suppressed until one clock after reset release, so the
    // first possible state change lands on the second rising edge.
    assign dl_rise   = armed &  bus.ioctl_download & ~dl_q;
    assign dl_fall   = armed & ~bus.ioctl_download &  dl_q;
    assign in_window = (state == S_LOAD) || (state == S_DRAIN);
    assign addr_ok   = bus.ioctl_addr < ROM_LIMIT;
    assign issue     = buf_valid & bus.slot_en;
    // A strobe landing on the same edge the buffer drains is still taken.
    assign accept    = in_window & bus.ioctl_wr & addr_ok & (~buf_valid | issue);
    assign reject    = in_window & bus.ioctl_wr & ~accept;
    assign hold_done = (hold_cnt <= 8'd1);

    assign bus.ioctl_wait = buf_valid;
    assign bus.dn_wr      = issue;
    // Outputs show the buffer only while writing, otherwise the last issued byte.
    assign bus.dn_addr    = issue ? buf_addr : out_addr;
    assign bus.dn_data    = issue ? buf_data : out_data;

    // State register plus reset-release arming and download edge history.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            armed <= 1'b0;
            dl_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            dl_q  <= armed ? bus.ioctl_download : 1'b0;
        end
    end

    // Next-state logic; a new download rise outranks soft_reset.
    always_comb begin
        state_nxt  = state;
        enter_load = 1'b0;
        enter_hold = 1'b0;
        drain_exit = 1'b0;
        if (armed) begin
            case (state)
                S_IDLE: begin
                    if (dl_rise) begin
                        state_nxt  = S_LOAD;
                        enter_load = 1'b1;
                    end
                end
                S_LOAD: begin
                    if (dl_fall) begin
                        state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (dl_rise) begin
                        state_nxt  = S_LOAD;
                        enter_load = 1'b1;
                    end else if (!buf_valid && !accept) begin
                        state_nxt  = S_HOLD;
                        enter_hold = 1'b1;
                        drain_exit = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (dl_rise) begin
                        state_nxt  = S_LOAD;
                        enter_load = 1'b1;
                    end else if (soft_reset) begin
                        state_nxt  = S_HOLD;
                        enter_hold = 1'b1;
                    end else if (hold_done) begin
                        state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (dl_rise) begin
                        state_nxt  = S_LOAD;
                        enter_load = 1'b1;
                    end else if (soft_reset) begin
                        state_nxt  = S_HOLD;
                        enter_hold = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Single-entry byte buffer; reset discards any pending byte.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (accept) begin
            buf_valid <= 1'b1;
            buf_addr  <= bus.ioctl_addr[15:0];
            buf_data  <= bus.ioctl_dout;
        end else if (issue) begin
            buf_valid <= 1'b0;
        end
    end

    // Remember the last issued byte so dn_addr/dn_data stay put between writes.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            out_addr <= '0;
            out_data <= '0;
        end else if (issue) begin
            out_addr <= buf_addr;
            out_data <= buf_data;
        end
    end

    // Issued-byte counter and overflow flag, both restarted with each download.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt <= '0;
            overflow <= 1'b0;
        end else if (enter_load) begin
            byte_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (issue && (byte_cnt != CNT_MAX)) begin
                byte_cnt <= byte_cnt + 17'd1;
            end
            if (reject) begin
                overflow <= 1'b1;
            end
        end
    end

    // Hold timer: loaded on every HOLD entry, counts down to terminal count 1.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (enter_hold) begin
            hold_cnt <= HOLD_LOAD;
        end else if ((state == S_HOLD) && (hold_cnt != 8'd0)) begin
            hold_cnt <= hold_cnt - 8'd1;
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            core_reset <= 1'b1;
            dl_done    <= 1'b0;
            dl_error   <= 1'b0;
        end else begin
            core_reset <= (state_nxt != S_RUN);
            dl_done    <= (state == S_HOLD) && (state_nxt == S_RUN) && !dl_error;
            if (drain_exit) begin
                dl_error <= overflow | reject | (byte_cnt != ROM_COUNT);
            end
        end
    end

endmodule
